// File: rtl/rc5_stream_loader_if.sv
// Byte-stream handshake bundle for rc5_stream_loader: an 8-bit input stream
// and an 8-bit output stream, each with valid/ready.
interface rc5_stream_loader_if;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;
    logic [7:0] oData;
    logic       oValid;
    logic       iReady;

    modport master (output iData, output iValid, input oReady,
                    input oData, input oValid, output iReady);
    modport slave  (input iData, input iValid, output oReady,
                    output oData, output oValid, input iReady);
endinterface

// File: rtl/rc5_stream_loader.sv
// Framed byte-stream front end for the RC5 engine: loads the key RAM, assembles
// one block, starts cipher/decipher and streams the A/B result back out.
module rc5_stream_loader #(
    parameter int W        = 16,
    parameter int B        = 16,
    parameter int B_LENGTH = $clog2(B)
) (
    input  logic                clk,
    input  logic                rst,
    rc5_stream_loader_if.slave  s,
    output logic [7:0]          oKey_sub_i,
    output logic [B_LENGTH-1:0] oKey_address,
    output logic                oWen,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oStartCipher,
    output logic                oStartDecipher,
    input  logic                iDoneCipher,
    input  logic                iDoneDecipher,
    input  logic [W-1:0]        iA_res,
    input  logic [W-1:0]        iB_res,
    output logic                oKeyLoaded,
    output logic                oErr
);
    localparam int BLK_BYTES = (2 * W) / 8;
    localparam int BCW       = $clog2(BLK_BYTES);
    localparam int CW        = $clog2((B > BLK_BYTES) ? B : BLK_BYTES);
    localparam logic [CW-1:0] KEY_LAST = CW'(B - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLK_BYTES - 1);
    localparam logic [7:0] CMD_KEY = 8'h01;
    localparam logic [7:0] CMD_ENC = 8'h02;
    localparam logic [7:0] CMD_DEC = 8'h03;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        BLOCK = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mode_q, mode_d;       // 0 = cipher, 1 = decipher
    logic [2*W-1:0]    ab_q, ab_d;
    logic [2*W-1:0]    res_q, res_d;
    logic [7:0]        key_q, key_d;
    logic [B_LENGTH-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic              loaded_q, loaded_d;
    logic [7:0]        data_q, data_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              cstart_q, cstart_d;
    logic              dstart_q, dstart_d;
    logic              in_xfer_s, out_xfer_s, done_s;
    logic [BCW-1:0]    blk_idx_s, nxt_idx_s;

    assign in_xfer_s  = s.iValid && ready_q;
    assign out_xfer_s = valid_q && s.iReady;
    assign done_s     = mode_q ? iDoneDecipher : iDoneCipher;
    assign blk_idx_s  = cnt_q[BCW-1:0];
    assign nxt_idx_s  = blk_idx_s + BCW'(1);

    // Next-state and registered-output computation for the frame FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        ab_d     = ab_q;
        res_d    = res_q;
        key_d    = key_q;
        addr_d   = addr_q;
        wen_d    = 1'b0;
        err_d    = 1'b0;
        loaded_d = loaded_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (in_xfer_s) begin
                    if (s.iData == CMD_KEY) begin
                        state_d  = KEY;
                        loaded_d = 1'b0;
                    end else if (((s.iData == CMD_ENC) || (s.iData == CMD_DEC)) && loaded_q) begin
                        state_d = BLOCK;
                        mode_d  = s.iData[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            KEY: begin
                if (in_xfer_s) begin
                    wen_d  = 1'b1;
                    addr_d = cnt_q[B_LENGTH-1:0];
                    key_d  = s.iData;
                    if (cnt_q == KEY_LAST) begin
                        cnt_d    = '0;
                        loaded_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            BLOCK: begin
                if (in_xfer_s) begin
                    ab_d[{blk_idx_s, 3'b000} +: 8] = s.iData;
                    if (cnt_q == BLK_LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done_s) begin
                    res_d   = {iB_res, iA_res};
                    data_d  = iA_res[7:0];
                    state_d = OUT;
                end else begin
                    state_d = WAIT;
                end
            end
            OUT: begin
                if (out_xfer_s) begin
                    if (cnt_q == BLK_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = res_q[{nxt_idx_s, 3'b000} +: 8];
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Handshake and start levels are registered decodes of the next state.
        ready_d  = (state_d == IDLE) || (state_d == KEY) || (state_d == BLOCK);
        valid_d  = (state_d == OUT);
        cstart_d = ((state_d == START) || (state_d == WAIT)) && !mode_d;
        dstart_d = ((state_d == START) || (state_d == WAIT)) && mode_d;
    end

    // State and output registers; reset clears everything except the key RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            ab_q     <= '0;
            res_q    <= '0;
            key_q    <= 8'h00;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            data_q   <= 8'h00;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            cstart_q <= 1'b0;
            dstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            ab_q     <= ab_d;
            res_q    <= res_d;
            key_q    <= key_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            cstart_q <= cstart_d;
            dstart_q <= dstart_d;
        end
    end

    assign s.oReady       = ready_q;
    assign s.oValid       = valid_q;
    assign s.oData        = data_q;
    assign oKey_sub_i     = key_q;
    assign oKey_address   = addr_q;
    assign oWen           = wen_q;
    assign oA             = ab_q[W-1:0];
    assign oB             = ab_q[2*W-1:W];
    assign oStartCipher   = cstart_q;
    assign oStartDecipher = dstart_q;
    assign oKeyLoaded     = loaded_q;
    assign oErr           = err_q;
endmodule

// File: tb/tb_rc5_stream_loader.sv
// Directed self-checking bench for rc5_stream_loader (W=16, B=16).
module tb_rc5_stream_loader;
    logic        clk;
    logic        rst;
    logic [7:0]  oKey_sub_i;
    logic [3:0]  oKey_address;
    logic        oWen;
    logic [15:0] oA, oB;
    logic        oStartCipher, oStartDecipher;
    logic        iDoneCipher, iDoneDecipher;
    logic [15:0] iA_res, iB_res;
    logic        oKeyLoaded, oErr;
    int          tests;
    int          fails;

    rc5_stream_loader_if bus ();

    rc5_stream_loader #(.W(16), .B(16)) dut (
        .clk(clk), .rst(rst), .s(bus.slave),
        .oKey_sub_i(oKey_sub_i), .oKey_address(oKey_address), .oWen(oWen),
        .oA(oA), .oB(oB),
        .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher),
        .iDoneCipher(iDoneCipher), .iDoneDecipher(iDoneDecipher),
        .iA_res(iA_res), .iB_res(iB_res),
        .oKeyLoaded(oKeyLoaded), .oErr(oErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.iData  = b;
        bus.iValid = 1'b1;
        while (!bus.oReady && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: oReady=%0b required 1", bus.oReady);
        end
        tick();
        bus.iValid = 1'b0;
    endtask

    task automatic collect(input int count, output logic [31:0] got, output int taken);
        int cyc;
        got   = 32'h0;
        taken = 0;
        cyc   = 0;
        bus.iReady = 1'b1;
        while (taken < count && cyc < 100) begin
            if (bus.oValid) begin
                got[8*taken +: 8] = bus.oData;
                taken++;
            end
            tick();
            cyc++;
        end
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        tests++;
        if ({bus.oReady, bus.oValid, oWen, oStartCipher, oStartDecipher, oKeyLoaded, oErr} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {bus.oReady, bus.oValid, oWen, oStartCipher, oStartDecipher, oKeyLoaded, oErr});
        end
        tests++;
        if ({oA, oB, bus.oData, oKey_address} !== 44'h0) begin
            fails++;
            $display("FAIL reset_data: oA=%h oB=%h oData=%h addr=%h required 0", oA, oB, bus.oData, oKey_address);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tests++;
        if (bus.oReady !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: oReady=%b required 1", bus.oReady);
        end
    endtask

    task automatic test_encrypt_before_key();
        send_byte(8'h02);
        tests++;
        if (oErr !== 1'b1) begin
            fails++;
            $display("FAIL nokey_err: oErr=%b required 1", oErr);
        end
        tick();
        tests++;
        if ({oErr, oStartCipher, bus.oReady} !== 3'b001) begin
            fails++;
            $display("FAIL nokey_after: err/start/ready=%b required 001", {oErr, oStartCipher, bus.oReady});
        end
    endtask

    task automatic test_key_load();
        logic [7:0] key [16];
        int bad;
        key = '{8'h91, 8'h5F, 8'h46, 8'h19, 8'hBE, 8'h41, 8'hB2, 8'h51,
                8'h63, 8'h55, 8'hA5, 8'h01, 8'h10, 8'hA9, 8'hCE, 8'h91};
        send_byte(8'h01);
        tests++;
        if (oKeyLoaded !== 1'b0) begin
            fails++;
            $display("FAIL key_loaded_cleared: oKeyLoaded=%b required 0", oKeyLoaded);
        end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            send_byte(key[k]);
            if (oWen !== 1'b1 || oKey_address !== 4'(k) || oKey_sub_i !== key[k]) begin
                bad++;
                $display("FAIL key_write%0d: wen=%b addr=%0d byte=%h required 1 %0d %h",
                         k, oWen, oKey_address, oKey_sub_i, k, key[k]);
            end
        end
        tests++;
        if (bad != 0) fails++;
        tick();
        tests++;
        if ({oWen, oKeyLoaded, bus.oReady} !== 3'b011) begin
            fails++;
            $display("FAIL key_done: wen/loaded/ready=%b required 011", {oWen, oKeyLoaded, bus.oReady});
        end
    endtask

    task automatic test_bad_cmd();
        send_byte(8'h7E);
        tests++;
        if ({oErr, oKeyLoaded} !== 2'b11) begin
            fails++;
            $display("FAIL bad_cmd: err/loaded=%b required 11", {oErr, oKeyLoaded});
        end
        tick();
    endtask

    task automatic test_encrypt();
        logic [31:0] got;
        int taken;
        iA_res = 16'h1234;
        iB_res = 16'hABCD;
        send_byte(8'h02);
        send_byte(8'h21); send_byte(8'hA5); send_byte(8'h15); send_byte(8'h4B);
        tests++;
        if ({oA, oB} !== {16'hA521, 16'h4B15} || {oStartCipher, oStartDecipher, bus.oReady} !== 3'b100) begin
            fails++;
            $display("FAIL enc_start: oA=%h oB=%h start c/d/ready=%b required A521 4B15 100",
                     oA, oB, {oStartCipher, oStartDecipher, bus.oReady});
        end
        iDoneDecipher = 1'b1;
        tick(); tick(); tick();
        tests++;
        if ({oStartCipher, bus.oValid} !== 2'b10) begin
            fails++;
            $display("FAIL enc_hold: start/valid=%b required 10", {oStartCipher, bus.oValid});
        end
        iDoneDecipher = 1'b0;
        iDoneCipher   = 1'b1;
        tick();
        iDoneCipher   = 1'b0;
        tests++;
        if ({oStartCipher, bus.oValid, bus.oData} !== {2'b01, 8'h34}) begin
            fails++;
            $display("FAIL enc_done: start/valid=%b oData=%h required 01 34",
                     {oStartCipher, bus.oValid}, bus.oData);
        end
        collect(4, got, taken);
        tests++;
        if (got !== 32'hABCD1234 || taken != 4) begin
            fails++;
            $display("FAIL enc_out: got %h (%0d bytes) required ABCD1234", got, taken);
        end
        tests++;
        if ({bus.oValid, bus.oReady} !== 2'b01) begin
            fails++;
            $display("FAIL enc_idle: valid/ready=%b required 01", {bus.oValid, bus.oReady});
        end
    endtask

    task automatic test_decrypt();
        logic [31:0] got;
        int taken;
        iA_res = 16'hA521;
        iB_res = 16'h4B15;
        send_byte(8'h03);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
        tests++;
        if ({oA, oB} !== {16'h1234, 16'hABCD} || {oStartCipher, oStartDecipher} !== 2'b01) begin
            fails++;
            $display("FAIL dec_start: oA=%h oB=%h start c/d=%b required 1234 ABCD 01",
                     oA, oB, {oStartCipher, oStartDecipher});
        end
        iDoneCipher = 1'b1;
        tick(); tick();
        iDoneCipher = 1'b0;
        tests++;
        if ({oStartDecipher, oStartCipher, bus.oValid} !== 3'b100) begin
            fails++;
            $display("FAIL dec_ignore_other: d/c/valid=%b required 100",
                     {oStartDecipher, oStartCipher, bus.oValid});
        end
        iDoneDecipher = 1'b1;
        tick();
        iDoneDecipher = 1'b0;
        collect(4, got, taken);
        tests++;
        if (got !== 32'h4B15A521 || taken != 4) begin
            fails++;
            $display("FAIL dec_out: got %h (%0d bytes) required 4B15A521", got, taken);
        end
    endtask

    task automatic test_done_early_backpressure();
        logic [31:0] got;
        int taken;
        int bad;
        iA_res = 16'hBEEF;
        iB_res = 16'h0102;
        iDoneCipher = 1'b1;
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        tick();
        tests++;
        if ({oStartCipher, bus.oValid} !== 2'b10) begin
            fails++;
            $display("FAIL early_wait: start/valid=%b required 10", {oStartCipher, bus.oValid});
        end
        tick();
        iDoneCipher = 1'b0;
        tests++;
        if ({oStartCipher, bus.oValid, bus.oData} !== {2'b01, 8'hEF}) begin
            fails++;
            $display("FAIL early_done: start/valid=%b oData=%h required 01 EF",
                     {oStartCipher, bus.oValid}, bus.oData);
        end
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.oValid !== 1'b1 || bus.oData !== 8'hBE) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_stable: %0d unstable cycles, oValid=%b oData=%h required 1 BE",
                     bad, bus.oValid, bus.oData);
        end
        collect(3, got, taken);
        tests++;
        if (got[23:0] !== 24'h0102BE || taken != 3) begin
            fails++;
            $display("FAIL bp_rest: got %h (%0d bytes) required 0102BE", got[23:0], taken);
        end
    endtask

    task automatic test_reset_mid_wait();
        send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        tick();
        tests++;
        if (oStartCipher !== 1'b1) begin
            fails++;
            $display("FAIL rmw_pre: oStartCipher=%b required 1", oStartCipher);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({oStartCipher, oStartDecipher, oKeyLoaded, bus.oReady, bus.oValid, oErr, oWen} !== 7'b0
            || {oA, oB} !== 32'h0) begin
            fails++;
            $display("FAIL rmw_reset: ctrl=%b oA=%h oB=%h required 0",
                     {oStartCipher, oStartDecipher, oKeyLoaded, bus.oReady, bus.oValid, oErr, oWen}, oA, oB);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        send_byte(8'h02);
        tests++;
        if ({oErr, oStartCipher} !== 2'b10) begin
            fails++;
            $display("FAIL rmw_reject: err/start=%b required 10", {oErr, oStartCipher});
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.iData = 8'h00;
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        iDoneCipher = 1'b0;
        iDoneDecipher = 1'b0;
        iA_res = 16'h0;
        iB_res = 16'h0;
        test_reset();
        test_encrypt_before_key();
        test_key_load();
        test_bad_cmd();
        test_encrypt();
        test_decrypt();
        test_done_early_backpressure();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rc5_stream_loader.md
Name: rc5_stream_loader

Overview:
- Byte-stream front end that sits directly upstream of the RC5 dut (key RAM + cipher/decipher engine).
- Accepts framed commands on an 8-bit valid/ready input stream. A frame either writes the B-byte key into the key RAM port, or assembles one 2W-bit block and runs cipher or decipher on it.
- Returns the engine's A/B result as a byte stream on an 8-bit valid/ready output.

Parameters:
- W, 16, word width in bits (multiple of 8); one block = 2*W/8 bytes.
- B, 16, key length in bytes.
- B_LENGTH, $clog2(B), key RAM address width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- iData  in  8  input stream byte.
- iValid  in  1  iData valid.
- oReady  out  1  loader accepts iData this cycle.
- oKey_sub_i  out  8  key byte to engine key RAM.
- oKey_address  out  B_LENGTH  key RAM address.
- oWen  out  1  key RAM write enable.
- oA, oB  out  W each  block words to engine.
- oStartCipher, oStartDecipher  out  1 each  level start to engine.
- iDoneCipher, iDoneDecipher  in  1 each  engine done.
- iA_res, iB_res  in  W each  engine result words (cipher or decipher output selected by mode).
- oData  out  8  output stream byte.
- oValid  out  1  oData valid.
- iReady  in  1  downstream accepts oData.
- oKeyLoaded  out  1  a complete key has been written.
- oErr  out  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including oReady, oWen, both starts, oValid, oKeyLoaded, oErr, oA, oB, oData, oKey_address. Asserting reset mid-operation aborts the frame and drops starts immediately. Key RAM contents are untouched.
- Transfer rules:
  - Input transfer = iValid && oReady; output transfer = oValid && iReady.
  - oData is held stable while oValid=1 and iReady=0.
- State machine:
  - IDLE:
    - oReady=1. The first accepted byte is the command.
    - 0x01 -> KEY.
    - 0x02 or 0x03 with oKeyLoaded=1 -> BLOCK, mode = cipher or decipher.
    - 0x02 or 0x03 with oKeyLoaded=0, or any other value: byte consumed, oErr=1 for one cycle, stay IDLE.
  - KEY:
    - oReady=1. Each accepted byte k (k = 0..B-1) produces oWen=1, oKey_address=k, oKey_sub_i=byte on the following cycle (registered, 1-cycle latency).
    - oKeyLoaded is cleared on entry to KEY and set after byte B-1 is written. Then -> IDLE.
  - BLOCK:
    - oReady=1. Accepts 2*W/8 bytes, little-endian: byte j (j < W/8) -> oA[8j+:8], remaining bytes -> oB likewise.
    - After the last byte -> START.
  - START:
    - oReady=0. Asserts the mode's start (one cycle after the last byte accepted) and holds it -> WAIT.
  - WAIT:
    - Start held high until the mode's done is sampled 1.
    - On that edge: capture iA_res/iB_res, deassert start, -> OUT.
    - The other mode's done is ignored. No timeout.
  - OUT:
    - oValid=1. Emits the 2*W/8 result bytes in the same little-endian order, A first.
    - Each byte advances only on an output transfer.
    - After the final byte's transfer -> IDLE; oValid=0 next cycle.
- Boundaries:
  - Only one start is ever high, and never in IDLE, KEY, BLOCK or OUT.
  - oA/oB stay stable from START until the next BLOCK frame begins.
  - A key frame is never interleaved with a block.
  - A new frame cannot be accepted until OUT completes (oReady=0 in START, WAIT and OUT).
  - Byte counters wrap to 0 on every state exit.
  - A done that is already high on entry to WAIT is honoured on the first WAIT cycle.

Test Plan:
- Key load: frame 0x01 followed by bytes 91 5F 46 19 BE 41 B2 51 63 55 A5 01 10 A9 CE 91 -> 16 oWen pulses at addresses 0..15 with those bytes, then oKeyLoaded=1.
- Encrypt before key: after reset, send 0x02 -> oErr pulses once, oStartCipher stays 0, loader returns to IDLE with oReady=1.
- Encrypt: with key loaded, send 0x02 21 A5 15 4B -> oA=0xA521, oB=0x4B15, oStartCipher high until iDoneCipher. Model the result as iA_res=0x1234, iB_res=0xABCD; output bytes must be 34 12 CD AB.
- Decrypt round trip: feed the encrypt output back as 0x03 plus 4 bytes -> oStartDecipher only; output must be 21 A5 15 4B.
- Backpressure: hold iReady=0 for 5 cycles mid-OUT -> oData and oValid stable, no byte lost or duplicated.
- Reset mid-WAIT: drive rst=0 while oStartCipher=1 -> start drops immediately, all outputs 0, oKeyLoaded=0. An encrypt after reset is then rejected with oErr.
